// File: rtl/frame_pattern_checker_pkg.sv
// frame_pattern_checker_pkg: pattern encodings, pixel constants and FSM states shared by checker and generator.
package frame_pattern_checker_pkg;
    typedef enum logic [2:0] {
        PAT_BLACK = 3'b000,
        PAT_WHITE = 3'b001,
        PAT_GRAD  = 3'b010,
        PAT_CHECK = 3'b011
    } pattern_e;
    typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_LINE, ST_REPORT} state_e;
    localparam logic [7:0] PIX_BLACK = 8'h00;
    localparam logic [7:0] PIX_WHITE = 8'hFF;
    // Smallest R with R*255 >= dval_high, so the gradient just fits one 8-bit ramp per line.
    function automatic int grad_rep(input int dval_high);
        return (dval_high + 254) / 255;
    endfunction
endpackage

// File: rtl/frame_expected_pix.sv
// frame_expected_pix: expected pixel for the current cycle, from gradient and checker band counters.
module frame_expected_pix
    import frame_pattern_checker_pkg::*;
#(
    parameter int DVAL_HIGH = 640,
    parameter int ROW_COUNT = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       line_start,
    input  logic       line_end,
    input  logic       pix_valid,
    input  logic [2:0] sel_ref,
    output logic [7:0] exp_pix
);
    localparam int R   = grad_rep(DVAL_HIGH);
    localparam int CBW = (DVAL_HIGH / 8) > 0 ? DVAL_HIGH / 8 : 1;
    localparam int RBH = (ROW_COUNT / 8) > 0 ? ROW_COUNT / 8 : 1;
    logic [15:0] rep, cbc, rbc, rep_e, cbc_e;
    logic [7:0]  grad, grad_e;
    logic [2:0]  cb, cb_e;
    logic [3:0]  rb;
    logic        chk;
    // Column-side counters read as zero on the line-start cycle so its pixel is column 0.
    always_comb begin
        rep_e   = line_start ? '0 : rep;
        cbc_e   = line_start ? '0 : cbc;
        grad_e  = line_start ? '0 : grad;
        cb_e    = line_start ? '0 : cb;
        chk     = (rb >= 4'd8) || (rb[0] ^ cb_e[0]);
        exp_pix = sel_ref == PAT_BLACK ? PIX_BLACK :
                  sel_ref == PAT_WHITE ? PIX_WHITE :
                  sel_ref == PAT_GRAD  ? grad_e :
                  chk ? PIX_WHITE : PIX_BLACK;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            rep  <= '0;
            cbc  <= '0;
            rbc  <= '0;
            grad <= '0;
            cb   <= '0;
            rb   <= '0;
        end else begin
            if (pix_valid) begin
                rep  <= rep_e == 16'(R - 1) ? '0 : rep_e + 16'd1;
                grad <= rep_e == 16'(R - 1) ? grad_e + 8'd1 : grad_e;
                cbc  <= cbc_e == 16'(CBW - 1) ? '0 : cbc_e + 16'd1;
                cb   <= (cbc_e == 16'(CBW - 1) && cb_e != 3'd7) ? cb_e + 3'd1 : cb_e;
            end else if (line_start) begin
                rep  <= '0;
                cbc  <= '0;
                grad <= '0;
                cb   <= '0;
            end
            if (frame_start) begin
                rbc <= '0;
                rb  <= '0;
            end else if (line_end) begin
                rbc <= rbc == 16'(RBH - 1) ? '0 : rbc + 16'd1;
                rb  <= (rbc == 16'(RBH - 1) && rb != 4'd8) ? rb + 4'd1 : rb;
            end
        end
    end
endmodule

// File: rtl/frame_pattern_checker.sv
// frame_pattern_checker: checks incoming video frames against a selected test pattern
// and reports pixel errors and frame geometry once per frame.
module frame_pattern_checker
    import frame_pattern_checker_pkg::*;
#(
    parameter int DVAL_HIGH = 640,
    parameter int ROW_COUNT = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  sel,
    input  logic        fval,
    input  logic        lval,
    input  logic        dval,
    input  logic [7:0]  pix_value,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [31:0] err_count,
    output logic [15:0] line_count,
    output logic [15:0] pix_per_line,
    output logic        geom_err,
    output logic        unsupported
);
    state_e      state;
    logic        fval_q, lval_q, geom_run, mism_q;
    logic [2:0]  sel_q, sel_ref;
    logic [15:0] col, row, last_col;
    logic [31:0] err_run;
    logic [7:0]  exp_pix;
    logic        fval_rise, fval_fall, lval_rise, lval_fall, line_start, line_end, pix_valid;
    assign fval_rise   = fval & ~fval_q;
    assign fval_fall   = ~fval & fval_q;
    assign lval_rise   = lval & ~lval_q;
    assign lval_fall   = ~lval & lval_q;
    assign line_start  = state == ST_FRAME && lval_rise && fval;
    // fval dropping inside a line closes that line before the frame is reported.
    assign line_end    = state == ST_LINE && (lval_fall || fval_fall);
    assign pix_valid   = fval && lval && dval && (state == ST_LINE || line_start);
    assign unsupported = sel_q[2];
    frame_expected_pix #(.DVAL_HIGH(DVAL_HIGH), .ROW_COUNT(ROW_COUNT)) u_exp (
        .clk        (clk),
        .rst        (rst),
        .frame_start(fval_rise),
        .line_start (line_start),
        .line_end   (line_end),
        .pix_valid  (pix_valid),
        .sel_ref    (sel_ref),
        .exp_pix    (exp_pix)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            // Take the live levels so a frame already in progress is not seen as a new rise.
            fval_q       <= fval;
            lval_q       <= lval;
            state        <= ST_IDLE;
            sel_q        <= '0;
            sel_ref      <= '0;
            col          <= '0;
            row          <= '0;
            last_col     <= '0;
            err_run      <= '0;
            geom_run     <= 1'b0;
            mism_q       <= 1'b0;
            frame_done   <= 1'b0;
            frame_ok     <= 1'b0;
            err_count    <= '0;
            line_count   <= '0;
            pix_per_line <= '0;
            geom_err     <= 1'b0;
        end else begin
            fval_q     <= fval;
            lval_q     <= lval;
            sel_q      <= sel;
            frame_done <= state == ST_REPORT;
            mism_q     <= pix_valid && !sel_ref[2] && pix_value != exp_pix;
            if (fval_rise) begin
                state    <= ST_FRAME;
                sel_ref  <= sel_q;
                col      <= '0;
                row      <= '0;
                err_run  <= '0;
                geom_run <= 1'b0;
            end else begin
                case (state)
                    ST_FRAME:  state <= fval_fall ? ST_REPORT : line_start ? ST_LINE : ST_FRAME;
                    ST_LINE:   state <= fval_fall ? ST_REPORT : lval_fall ? ST_FRAME : ST_LINE;
                    default:   state <= ST_IDLE;
                endcase
                if (line_start)
                    col <= pix_valid ? 16'd1 : 16'd0;
                else if (pix_valid && col != '1)
                    col <= col + 16'd1;
                if (line_end) begin
                    geom_run <= geom_run | (col != 16'(DVAL_HIGH));
                    last_col <= col;
                    if (row != '1)
                        row <= row + 16'd1;
                end
                if (mism_q && err_run != '1)
                    err_run <= err_run + 32'd1;
            end
            if (state == ST_REPORT) begin
                err_count    <= err_run;
                line_count   <= row;
                pix_per_line <= last_col;
                geom_err     <= geom_run | (row != 16'(ROW_COUNT));
                frame_ok     <= !geom_run && row == 16'(ROW_COUNT) && err_run == '0;
            end
        end
    end
endmodule

// File: tb/tb_frame_pattern_checker.sv
// tb_frame_pattern_checker: directed frames on a reduced 512x9 geometry (gradient repeat 3,
// checker bands 64 columns x 1 row, row 8 is the remainder band).
module tb_frame_pattern_checker;
    localparam int DH = 512;
    localparam int RC = 9;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  sel = 3'b111;
    logic        fval = 1'b0, lval = 1'b0, dval = 1'b0;
    logic [7:0]  pix_value = 8'h00;
    logic        frame_done, frame_ok, geom_err, unsupported;
    logic [31:0] err_count;
    logic [15:0] line_count, pix_per_line;
    int n_chk = 0, n_fail = 0, done_cnt = 0;
    int cfg_lines, cfg_short_line, cfg_short_len, cfg_err_line, cfg_err_col, cfg_abort_row, cfg_toggle_row;
    bit cfg_invert, cfg_gaps, cfg_end_together;
    always #5 clk = ~clk;
    frame_pattern_checker #(.DVAL_HIGH(DH), .ROW_COUNT(RC)) dut (
        .clk         (clk),
        .rst         (rst),
        .sel         (sel),
        .fval        (fval),
        .lval        (lval),
        .dval        (dval),
        .pix_value   (pix_value),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .err_count   (err_count),
        .line_count  (line_count),
        .pix_per_line(pix_per_line),
        .geom_err    (geom_err),
        .unsupported (unsupported)
    );
    function automatic logic [7:0] model(input logic [2:0] s, input int r, input int c);
        int rb, cb;
        rb = r / (RC / 8);
        cb = c / (DH / 8);
        if (cb > 7) cb = 7;
        case (s)
            3'b000:  return 8'h00;
            3'b001:  return 8'hFF;
            3'b010:  return 8'((c / 3) % 256);
            3'b011:  return (rb >= 8 || ((rb ^ cb) & 1) == 1) ? 8'hFF : 8'h00;
            default: return 8'(c * 7);
        endcase
    endfunction
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic clear_cfg();
        cfg_lines = RC; cfg_short_line = -1; cfg_short_len = DH; cfg_err_line = -1; cfg_err_col = -1;
        cfg_abort_row = -1; cfg_toggle_row = -1; cfg_invert = 0; cfg_gaps = 0; cfg_end_together = 0;
    endtask
    task automatic run_frame(input logic [2:0] psel);
        int n;
        sel = psel;
        tick(); tick();
        fval = 1'b1;
        tick(); tick();
        for (int r = 0; r < cfg_lines; r++) begin
            if (r == cfg_abort_row) begin
                rst = 1'b0; tick(); tick(); rst = 1'b1; tick();
            end
            if (r == cfg_toggle_row) sel = psel ^ 3'b001;
            n = (r == cfg_short_line) ? cfg_short_len : DH;
            lval = 1'b1;
            for (int c = 0; c < n;) begin
                if (cfg_gaps && $urandom_range(0, 4) == 0) begin
                    dval = 1'b0;
                    pix_value = 8'($urandom);
                end else begin
                    dval = 1'b1;
                    pix_value = model(psel, r, c);
                    if (cfg_invert) pix_value = ~pix_value;
                    if (r == cfg_err_line && c == cfg_err_col) pix_value = 8'h00;
                    c++;
                end
                tick();
            end
            dval = 1'b0;
            if (!(cfg_end_together && r == cfg_lines - 1)) begin
                lval = 1'b0; tick();
                dval = 1'b1; pix_value = 8'h5A; tick();
                dval = 1'b0; tick();
            end
        end
        fval = 1'b0; lval = 1'b0; dval = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (frame_done) done_cnt++;
        end
    endtask
    initial begin
        clear_cfg();
        tick(); tick();
        check("rst_done", 32'(frame_done), 0);
        check("rst_ok", 32'(frame_ok), 0);
        check("rst_err", err_count, 0);
        check("rst_lines", 32'(line_count), 0);
        check("rst_ppl", 32'(pix_per_line), 0);
        check("rst_geom", 32'(geom_err), 0);
        check("rst_unsup", 32'(unsupported), 0);
        rst = 1'b1;
        tick();
        check("unsup_after_rst", 32'(unsupported), 1);
        run_frame(3'b001);
        check("white_done", done_cnt, 1);
        check("white_ok", 32'(frame_ok), 1);
        check("white_err", err_count, 0);
        check("white_lines", 32'(line_count), RC);
        check("white_ppl", 32'(pix_per_line), DH);
        check("white_geom", 32'(geom_err), 0);
        check("white_unsup", 32'(unsupported), 0);
        clear_cfg(); cfg_gaps = 1;
        run_frame(3'b010);
        check("grad_ok", 32'(frame_ok), 1);
        check("grad_err", err_count, 0);
        clear_cfg(); cfg_err_line = 7; cfg_err_col = 300;
        run_frame(3'b010);
        check("grad_bad_err", err_count, 1);
        check("grad_bad_ok", 32'(frame_ok), 0);
        check("grad_bad_geom", 32'(geom_err), 0);
        clear_cfg();
        run_frame(3'b011);
        check("chk_ok", 32'(frame_ok), 1);
        check("chk_err", err_count, 0);
        clear_cfg(); cfg_invert = 1;
        run_frame(3'b011);
        check("chk_inv_err", err_count, DH * RC);
        check("chk_inv_ok", 32'(frame_ok), 0);
        clear_cfg(); cfg_end_together = 1; cfg_err_line = RC - 1; cfg_err_col = DH - 1;
        run_frame(3'b011);
        check("lastpix_done", done_cnt, 1);
        check("lastpix_err", err_count, 1);
        check("lastpix_lines", 32'(line_count), RC);
        check("lastpix_geom", 32'(geom_err), 0);
        clear_cfg(); cfg_short_line = 5; cfg_short_len = DH - 1; cfg_lines = RC - 1;
        run_frame(3'b000);
        check("geom_geom", 32'(geom_err), 1);
        check("geom_lines", 32'(line_count), RC - 1);
        check("geom_ok", 32'(frame_ok), 0);
        check("geom_err_cnt", err_count, 0);
        check("geom_ppl", 32'(pix_per_line), DH);
        clear_cfg();
        run_frame(3'b101);
        check("unsup_flag", 32'(unsupported), 1);
        check("unsup_done", done_cnt, 1);
        check("unsup_err", err_count, 0);
        check("unsup_ok", 32'(frame_ok), 1);
        clear_cfg(); cfg_abort_row = 5;
        run_frame(3'b001);
        check("abort_done", done_cnt, 0);
        check("abort_ok", 32'(frame_ok), 0);
        check("abort_lines", 32'(line_count), 0);
        clear_cfg();
        run_frame(3'b001);
        check("clean_done", done_cnt, 1);
        check("clean_ok", 32'(frame_ok), 1);
        clear_cfg(); cfg_toggle_row = 4;
        run_frame(3'b001);
        check("toggle_done", done_cnt, 1);
        check("toggle_ok", 32'(frame_ok), 1);
        check("toggle_err", err_count, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
